// File: rtl/reorder_buffer_if.sv
// reorder_buffer_if: allocation, completion and in-order output ports of the reorder buffer
interface reorder_buffer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int TAG_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
);
  logic                  alloc_valid_i;
  logic                  alloc_ready_o;
  logic [TAG_WIDTH-1:0]  alloc_tag_o;
  logic                  rsp_valid_i;
  logic [TAG_WIDTH-1:0]  rsp_tag_i;
  logic [DATA_WIDTH-1:0] rsp_data_i;
  logic                  out_valid_o;
  logic [DATA_WIDTH-1:0] out_data_o;
  logic                  out_ready_i;
  logic [TAG_WIDTH:0]    count_o;
  logic                  err_o;
  modport master (
    output alloc_valid_i, rsp_valid_i, rsp_tag_i, rsp_data_i, out_ready_i,
    input  alloc_ready_o, alloc_tag_o, out_valid_o, out_data_o, count_o, err_o
  );
  modport slave (
    input  alloc_valid_i, rsp_valid_i, rsp_tag_i, rsp_data_i, out_ready_i,
    output alloc_ready_o, alloc_tag_o, out_valid_o, out_data_o, count_o, err_o
  );
endinterface

// File: rtl/reorder_buffer.sv
// reorder_buffer: hands out slot tags, accepts tagged completions in any order, releases them in allocation order
module reorder_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int TAG_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input logic             clk_i,
  input logic             rst_i,
  reorder_buffer_if.slave bus
);
  localparam logic [TAG_WIDTH-1:0] LAST = TAG_WIDTH'(DEPTH - 1);
  localparam logic [TAG_WIDTH-1:0] TAG_ONE = TAG_WIDTH'(1);
  localparam logic [TAG_WIDTH:0]   FULL = (TAG_WIDTH + 1)'(DEPTH);
  localparam logic [TAG_WIDTH:0]   CNT_ONE = (TAG_WIDTH + 1)'(1);
  logic [TAG_WIDTH-1:0]  head_q, head_d, tail_q, tail_d;
  logic                  head_wrap_q, head_wrap_d, tail_wrap_q, tail_wrap_d;
  logic [DEPTH-1:0]      alloc_q, alloc_d, done_q, done_d;
  logic [TAG_WIDTH:0]    count_q, count_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]      head_oh, tail_oh, rsp_oh;
  logic                  do_alloc, do_pop, rsp_ok, tag_in_rng;
  assign bus.alloc_ready_o = count_q < FULL;
  assign bus.alloc_tag_o   = tail_q;
  assign bus.out_valid_o   = |(done_q & head_oh);
  assign bus.out_data_o    = data_q[head_q];
  assign bus.count_o       = count_q;
  assign bus.err_o         = err_q;
  // handshakes, completion legality and next-state of indices, slot bits and count
  always_comb begin
    head_oh     = DEPTH'(1) << head_q;
    tail_oh     = DEPTH'(1) << tail_q;
    tag_in_rng  = {1'b0, bus.rsp_tag_i} < FULL;
    rsp_oh      = tag_in_rng ? DEPTH'(1) << bus.rsp_tag_i : '0;
    do_alloc    = bus.alloc_valid_i && bus.alloc_ready_o;
    do_pop      = bus.out_valid_o && bus.out_ready_i;
    rsp_ok      = bus.rsp_valid_i && |(rsp_oh & alloc_q & ~done_q);
    err_d       = bus.rsp_valid_i && !rsp_ok;
    head_d      = do_pop ? (head_q == LAST ? '0 : head_q + TAG_ONE) : head_q;
    head_wrap_d = head_wrap_q ^ (do_pop && head_q == LAST);
    tail_d      = do_alloc ? (tail_q == LAST ? '0 : tail_q + TAG_ONE) : tail_q;
    tail_wrap_d = tail_wrap_q ^ (do_alloc && tail_q == LAST);
    alloc_d     = (alloc_q & ~(do_pop ? head_oh : '0)) | (do_alloc ? tail_oh : '0);
    done_d      = (done_q & ~(do_pop ? head_oh : '0)) | (rsp_ok ? rsp_oh : '0);
    count_d     = (do_alloc && !do_pop) ? count_q + CNT_ONE :
                  (!do_alloc && do_pop) ? count_q - CNT_ONE : count_q;
  end
  // control state; reset discards every outstanding transaction
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q      <= '0;
      tail_q      <= '0;
      head_wrap_q <= 1'b0;
      tail_wrap_q <= 1'b0;
      alloc_q     <= '0;
      done_q      <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      head_wrap_q <= head_wrap_d;
      tail_wrap_q <= tail_wrap_d;
      alloc_q     <= alloc_d;
      done_q      <= done_d;
      count_q     <= count_d;
      err_q       <= err_d;
    end
  end
  // completion data store; contents only matter once the slot is marked done
  always_ff @(posedge clk_i) begin
    if (rsp_ok) data_q[bus.rsp_tag_i] <= bus.rsp_data_i;
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed scenarios plus randomized run against an in-order queue model
module tb_reorder_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  reorder_buffer_if #(.DATA_WIDTH(8), .DEPTH(4)) b4 ();
  reorder_buffer_if #(.DATA_WIDTH(8), .DEPTH(3)) b3 ();
  reorder_buffer #(.DATA_WIDTH(8), .DEPTH(4)) dut4 (.clk_i(clk), .rst_i(rst), .bus(b4.slave));
  reorder_buffer #(.DATA_WIDTH(8), .DEPTH(3)) dut3 (.clk_i(clk), .rst_i(rst), .bus(b3.slave));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    b4.alloc_valid_i = 0; b4.rsp_valid_i = 0; b4.rsp_tag_i = 0; b4.rsp_data_i = 0; b4.out_ready_i = 0;
    b3.alloc_valid_i = 0; b3.rsp_valid_i = 0; b3.rsp_tag_i = 0; b3.rsp_data_i = 0; b3.out_ready_i = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    tick();
    rst = 0;
    tick();
    checks++; if (b4.alloc_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", b4.alloc_ready_o); end
    checks++; if (b4.alloc_tag_o !== 2'd0) begin errors++; $display("FAIL reset_tag got=%0d exp=0", b4.alloc_tag_o); end
    checks++; if (b4.out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", b4.out_valid_o); end
    checks++; if (b4.count_o !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", b4.count_o); end
    checks++; if (b4.err_o !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", b4.err_o); end
    checks++; if (b3.alloc_ready_o !== 1'b1 || b3.count_o !== 2'd0) begin errors++; $display("FAIL reset_d3 got ready=%b count=%0d exp ready=1 count=0", b3.alloc_ready_o, b3.count_o); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      checks++; if (b4.alloc_ready_o !== 1'b1 || b4.alloc_tag_o !== 2'(i)) begin errors++; $display("FAIL fill_tag%0d got ready=%b tag=%0d exp ready=1 tag=%0d", i, b4.alloc_ready_o, b4.alloc_tag_o, i); end
      b4.alloc_valid_i = 1;
      tick();
    end
    checks++; if (b4.alloc_ready_o !== 1'b0) begin errors++; $display("FAIL fill_full_ready got=%b exp=0", b4.alloc_ready_o); end
    checks++; if (b4.count_o !== 3'd4) begin errors++; $display("FAIL fill_count got=%0d exp=4", b4.count_o); end
    tick();
    checks++; if (b4.count_o !== 3'd4) begin errors++; $display("FAIL fill_fifth_granted got count=%0d exp=4", b4.count_o); end
    b4.alloc_valid_i = 0;
  endtask

  task automatic test_out_of_order();
    logic [7:0] d [4];
    int ord [4] = '{3, 1, 0, 2};
    bit ev [4] = '{0, 0, 1, 1};
    int ec [4] = '{4, 4, 4, 3};
    for (int t = 0; t < 4; t++) d[t] = 8'($urandom);
    b4.out_ready_i = 1;
    for (int k = 0; k < 4; k++) begin
      b4.rsp_valid_i = 1; b4.rsp_tag_i = 2'(ord[k]); b4.rsp_data_i = d[ord[k]];
      tick();
      checks++; if (b4.out_valid_o !== ev[k]) begin errors++; $display("FAIL ooo_valid%0d got=%b exp=%b", k, b4.out_valid_o, ev[k]); end
      checks++; if (b4.count_o !== 3'(ec[k])) begin errors++; $display("FAIL ooo_count%0d got=%0d exp=%0d", k, b4.count_o, ec[k]); end
      if (ev[k]) begin
        checks++; if (b4.out_data_o !== d[k-2]) begin errors++; $display("FAIL ooo_data%0d got=%h exp=%h", k, b4.out_data_o, d[k-2]); end
      end
    end
    b4.rsp_valid_i = 0;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++; if (b4.out_valid_o !== 1'b1 || b4.out_data_o !== d[2+k]) begin errors++; $display("FAIL ooo_drain%0d got valid=%b data=%h exp valid=1 data=%h", k, b4.out_valid_o, b4.out_data_o, d[2+k]); end
      checks++; if (b4.count_o !== 3'(2 - k)) begin errors++; $display("FAIL ooo_drain_count%0d got=%0d exp=%0d", k, b4.count_o, 2 - k); end
    end
    tick();
    checks++; if (b4.out_valid_o !== 1'b0 || b4.count_o !== 3'd0) begin errors++; $display("FAIL ooo_empty got valid=%b count=%0d exp valid=0 count=0", b4.out_valid_o, b4.count_o); end
    b4.out_ready_i = 0;
  endtask

  task automatic test_backpressure();
    logic [7:0] a, b;
    a = 8'($urandom); b = ~a;
    b4.alloc_valid_i = 1;
    tick();
    tick();
    b4.alloc_valid_i = 0;
    b4.rsp_valid_i = 1; b4.rsp_tag_i = 2'd0; b4.rsp_data_i = a;
    tick();
    b4.rsp_valid_i = 0;
    for (int s = 0; s < 5; s++) begin
      checks++; if (b4.out_valid_o !== 1'b1 || b4.out_data_o !== a) begin errors++; $display("FAIL bp_hold%0d got valid=%b data=%h exp valid=1 data=%h", s, b4.out_valid_o, b4.out_data_o, a); end
      b4.rsp_valid_i = (s == 1); b4.rsp_tag_i = 2'd1; b4.rsp_data_i = b;
      tick();
    end
    b4.rsp_valid_i = 0;
    checks++; if (b4.out_valid_o !== 1'b1 || b4.out_data_o !== a || b4.count_o !== 3'd2) begin errors++; $display("FAIL bp_end got valid=%b data=%h count=%0d exp valid=1 data=%h count=2", b4.out_valid_o, b4.out_data_o, b4.count_o, a); end
    b4.out_ready_i = 1;
    tick();
    checks++; if (b4.out_valid_o !== 1'b1 || b4.out_data_o !== b || b4.count_o !== 3'd1) begin errors++; $display("FAIL bp_retained got valid=%b data=%h count=%0d exp valid=1 data=%h count=1", b4.out_valid_o, b4.out_data_o, b4.count_o, b); end
    tick();
    checks++; if (b4.out_valid_o !== 1'b0 || b4.count_o !== 3'd0) begin errors++; $display("FAIL bp_empty got valid=%b count=%0d exp valid=0 count=0", b4.out_valid_o, b4.count_o); end
    b4.out_ready_i = 0;
  endtask

  task automatic test_errors();
    b4.rsp_valid_i = 1; b4.rsp_tag_i = 2'd2; b4.rsp_data_i = 8'h77;
    tick();
    b4.rsp_valid_i = 0;
    checks++; if (b4.err_o !== 1'b1) begin errors++; $display("FAIL err_unalloc got=%b exp=1", b4.err_o); end
    checks++; if (b4.count_o !== 3'd0 || b4.out_valid_o !== 1'b0) begin errors++; $display("FAIL err_unalloc_state got count=%0d valid=%b exp count=0 valid=0", b4.count_o, b4.out_valid_o); end
    tick();
    checks++; if (b4.err_o !== 1'b0) begin errors++; $display("FAIL err_pulse_width got=%b exp=0", b4.err_o); end
    checks++; if (b4.alloc_tag_o !== 2'd2) begin errors++; $display("FAIL err_tail got=%0d exp=2", b4.alloc_tag_o); end
    b4.alloc_valid_i = 1;
    tick();
    b4.alloc_valid_i = 0;
    b4.rsp_valid_i = 1; b4.rsp_tag_i = 2'd2; b4.rsp_data_i = 8'h33;
    tick();
    checks++; if (b4.err_o !== 1'b0 || b4.out_valid_o !== 1'b1 || b4.out_data_o !== 8'h33) begin errors++; $display("FAIL err_legal got err=%b valid=%b data=%h exp err=0 valid=1 data=33", b4.err_o, b4.out_valid_o, b4.out_data_o); end
    b4.rsp_data_i = 8'h44;
    tick();
    b4.rsp_valid_i = 0;
    checks++; if (b4.err_o !== 1'b1) begin errors++; $display("FAIL err_dup got=%b exp=1", b4.err_o); end
    checks++; if (b4.out_data_o !== 8'h33 || b4.count_o !== 3'd1) begin errors++; $display("FAIL err_dup_state got data=%h count=%0d exp data=33 count=1", b4.out_data_o, b4.count_o); end
    tick();
    checks++; if (b4.err_o !== 1'b0) begin errors++; $display("FAIL err_dup_width got=%b exp=0", b4.err_o); end
    b4.alloc_valid_i = 1; b4.rsp_valid_i = 1; b4.rsp_tag_i = 2'd3; b4.rsp_data_i = 8'h55;
    tick();
    b4.alloc_valid_i = 0; b4.rsp_valid_i = 0;
    checks++; if (b4.err_o !== 1'b1 || b4.count_o !== 3'd2) begin errors++; $display("FAIL err_same_cycle got err=%b count=%0d exp err=1 count=2", b4.err_o, b4.count_o); end
    b4.out_ready_i = 1;
    tick();
    b4.out_ready_i = 0;
    checks++; if (b4.out_valid_o !== 1'b0 || b4.count_o !== 3'd1) begin errors++; $display("FAIL err_same_cycle_done got valid=%b count=%0d exp valid=0 count=1", b4.out_valid_o, b4.count_o); end
    b4.rsp_valid_i = 1; b4.rsp_tag_i = 2'd3; b4.rsp_data_i = 8'h66;
    tick();
    b4.rsp_valid_i = 0;
    checks++; if (b4.err_o !== 1'b0 || b4.out_valid_o !== 1'b1 || b4.out_data_o !== 8'h66) begin errors++; $display("FAIL err_recover got err=%b valid=%b data=%h exp err=0 valid=1 data=66", b4.err_o, b4.out_valid_o, b4.out_data_o); end
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    b4.alloc_valid_i = 1;
    tick(); tick(); tick();
    b4.alloc_valid_i = 0;
    b4.rsp_valid_i = 1; b4.rsp_tag_i = 2'd0; b4.rsp_data_i = 8'h99;
    tick();
    b4.rsp_valid_i = 0;
    checks++; if (b4.out_valid_o !== 1'b1 || b4.count_o !== 3'd3) begin errors++; $display("FAIL rmid_pre got valid=%b count=%0d exp valid=1 count=3", b4.out_valid_o, b4.count_o); end
    #2 rst = 1;
    #1;
    checks++; if (b4.alloc_ready_o !== 1'b1 || b4.alloc_tag_o !== 2'd0) begin errors++; $display("FAIL rmid_alloc got ready=%b tag=%0d exp ready=1 tag=0", b4.alloc_ready_o, b4.alloc_tag_o); end
    checks++; if (b4.out_valid_o !== 1'b0 || b4.count_o !== 3'd0 || b4.err_o !== 1'b0) begin errors++; $display("FAIL rmid_out got valid=%b count=%0d err=%b exp 0 0 0", b4.out_valid_o, b4.count_o, b4.err_o); end
    #1 rst = 0;
    b4.alloc_valid_i = 1;
    tick();
    b4.alloc_valid_i = 0;
    checks++; if (b4.count_o !== 3'd1 || b4.alloc_tag_o !== 2'd1) begin errors++; $display("FAIL rmid_next got count=%0d tag=%0d exp count=1 tag=1", b4.count_o, b4.alloc_tag_o); end
  endtask

  task automatic test_wrap();
    logic [7:0] v;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      v = 8'($urandom);
      checks++; if (b3.alloc_ready_o !== 1'b1 || b3.alloc_tag_o !== 2'(i % 3)) begin errors++; $display("FAIL wrap_tag%0d got ready=%b tag=%0d exp ready=1 tag=%0d", i, b3.alloc_ready_o, b3.alloc_tag_o, i % 3); end
      b3.alloc_valid_i = 1;
      tick();
      b3.alloc_valid_i = 0;
      b3.rsp_valid_i = 1; b3.rsp_tag_i = 2'(i % 3); b3.rsp_data_i = v;
      tick();
      b3.rsp_valid_i = 0;
      checks++; if (b3.out_valid_o !== 1'b1 || b3.out_data_o !== v) begin errors++; $display("FAIL wrap_data%0d got valid=%b data=%h exp valid=1 data=%h", i, b3.out_valid_o, b3.out_data_o, v); end
      b3.out_ready_i = 1;
      tick();
      b3.out_ready_i = 0;
      checks++; if (b3.out_valid_o !== 1'b0 || b3.count_o !== 2'd0) begin errors++; $display("FAIL wrap_pop%0d got valid=%b count=%0d exp valid=0 count=0", i, b3.out_valid_o, b3.count_o); end
    end
    b3.alloc_valid_i = 1;
    tick();
    b3.alloc_valid_i = 0;
    b3.rsp_valid_i = 1; b3.rsp_tag_i = 2'd3; b3.rsp_data_i = 8'hEE;
    tick();
    b3.rsp_valid_i = 0;
    checks++; if (b3.err_o !== 1'b1 || b3.out_valid_o !== 1'b0 || b3.count_o !== 2'd1) begin errors++; $display("FAIL wrap_oor got err=%b valid=%b count=%0d exp err=1 valid=0 count=1", b3.err_o, b3.out_valid_o, b3.count_o); end
  endtask

  task automatic test_random();
    int q [$];
    bit mdone [4];
    logic [7:0] mdata [4];
    int next_tag = 0;
    bit merr = 0;
    bit av, rv, ordy, legal, exp_valid, pop;
    int rt, pick;
    logic [7:0] rd;
    int cand [$];
    do_reset();
    for (int t = 0; t < 4; t++) mdone[t] = 0;
    for (int n = 0; n < 1500; n++) begin
      exp_valid = q.size() > 0 && mdone[q[0]];
      checks++; if (b4.alloc_ready_o !== (q.size() < 4) || b4.alloc_tag_o !== 2'(next_tag)) begin errors++; $display("FAIL rnd_alloc@%0d got ready=%b tag=%0d exp ready=%b tag=%0d", n, b4.alloc_ready_o, b4.alloc_tag_o, q.size() < 4, next_tag); end
      checks++; if (b4.out_valid_o !== exp_valid || b4.count_o !== 3'(q.size())) begin errors++; $display("FAIL rnd_out@%0d got valid=%b count=%0d exp valid=%b count=%0d", n, b4.out_valid_o, b4.count_o, exp_valid, q.size()); end
      checks++; if (b4.err_o !== merr) begin errors++; $display("FAIL rnd_err@%0d got=%b exp=%b", n, b4.err_o, merr); end
      if (exp_valid) begin
        checks++; if (b4.out_data_o !== mdata[q[0]]) begin errors++; $display("FAIL rnd_data@%0d got=%h exp=%h", n, b4.out_data_o, mdata[q[0]]); end
      end
      av = ($urandom % 3) != 0;
      ordy = ($urandom % 4) != 0;
      rv = ($urandom % 4) != 0;
      rd = 8'($urandom);
      cand.delete();
      foreach (q[i]) if (!mdone[q[i]]) cand.push_back(q[i]);
      pick = int'($urandom % 8);
      rt = (pick != 0 && cand.size() > 0) ? cand[$urandom % cand.size()] : int'($urandom % 4);
      b4.alloc_valid_i = av; b4.out_ready_i = ordy;
      b4.rsp_valid_i = rv; b4.rsp_tag_i = 2'(rt); b4.rsp_data_i = rd;
      legal = 0;
      foreach (q[i]) if (q[i] == rt && !mdone[rt]) legal = rv;
      merr = rv && !legal;
      pop = exp_valid && ordy;
      if (legal) begin mdone[rt] = 1; mdata[rt] = rd; end
      if (pop) begin mdone[q[0]] = 0; void'(q.pop_front()); end
      if (av && q.size() + (pop ? 1 : 0) < 4) begin q.push_back(next_tag); next_tag = (next_tag + 1) % 4; end
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_out_of_order();
    test_backpressure();
    test_errors();
    test_reset_mid_op();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
